// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory fetch bus: one request outstanding at a time, completed
// by imem_ready. The fetch unit is the master; the memory is the slave.
interface fetch_pc_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;

   modport master (output imem_req, output imem_addr,
                   input  imem_ready, input imem_rdata);
   modport slave  (input  imem_req, input imem_addr,
                   output imem_ready, output imem_rdata);
endinterface

// File: rtl/fetch_pc_unit.sv
// Program counter and instruction fetch stage. Fetches one word at a time,
// holds it for decode until accepted, and folds jump/branch redirects in,
// including redirects that arrive while a fetch is still outstanding.
module fetch_pc_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   stall,
   input  logic                   jump,
   input  logic [31:0]            jump_target,
   input  logic                   branch_taken,
   input  logic [31:0]            branch_target,
   fetch_pc_unit_if.master        imem,
   output logic                   inst_valid,
   output logic [31:0]            inst,
   output logic [31:0]            pc_out,
   output logic [31:0]            pc_plus4
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] pc_out_q, pc_out_d;
   logic        inst_valid_q, inst_valid_d;
   logic        pend_valid_q, pend_valid_d;
   logic [31:0] pend_target_q, pend_target_d;

   logic        redir;
   logic [31:0] redir_tgt;

   // Redirect this cycle; jump beats branch, target forced word-aligned.
   always_comb begin
      redir     = jump | branch_taken;
      redir_tgt = (jump ? jump_target : branch_target) & 32'hFFFF_FFFC;
   end

   // Next-state and register updates for the fetch/hold sequencing.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      inst_d        = inst_q;
      pc_out_d      = pc_out_q;
      inst_valid_d  = inst_valid_q;
      pend_valid_d  = pend_valid_q;
      pend_target_d = pend_target_q;

      case (state_q)
         S_IDLE: begin
            // imem_ready here belongs to a request abandoned by reset.
            inst_valid_d = 1'b0;
            state_d      = S_FETCH;
         end
         S_FETCH: begin
            if (imem.imem_ready) begin
               if (redir) begin
                  // Data is for the old path; refetch at the fresh target.
                  pc_d         = redir_tgt;
                  pend_valid_d = 1'b0;
               end else if (pend_valid_q) begin
                  pc_d         = pend_target_q;
                  pend_valid_d = 1'b0;
               end else begin
                  inst_d       = imem.imem_rdata;
                  pc_out_d     = pc_q;
                  pc_d         = pc_q + 32'd4;
                  inst_valid_d = 1'b1;
                  state_d      = S_HOLD;
               end
            end else if (redir) begin
               // Request in flight keeps its address; remember the redirect.
               pend_valid_d  = 1'b1;
               pend_target_d = redir_tgt;
            end
         end
         S_HOLD: begin
            if (redir) begin
               pc_d         = redir_tgt;
               inst_valid_d = 1'b0;
               state_d      = S_FETCH;
            end else if (!stall) begin
               inst_valid_d = 1'b0;
               state_d      = S_FETCH;
            end
         end
         default: begin
            inst_valid_d = 1'b0;
            state_d      = S_IDLE;
         end
      endcase
   end

   // State and datapath registers, synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         pc_q          <= RESET_PC;
         inst_q        <= 32'd0;
         pc_out_q      <= 32'd0;
         inst_valid_q  <= 1'b0;
         pend_valid_q  <= 1'b0;
         pend_target_q <= 32'd0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         inst_q        <= inst_d;
         pc_out_q      <= pc_out_d;
         inst_valid_q  <= inst_valid_d;
         pend_valid_q  <= pend_valid_d;
         pend_target_q <= pend_target_d;
      end
   end

   // Outputs: request and address decode from registers only.
   always_comb begin
      imem.imem_req  = (state_q == S_FETCH);
      imem.imem_addr = pc_q;
      inst_valid     = inst_valid_q;
      inst           = inst_q;
      pc_out         = pc_out_q;
      pc_plus4       = pc_out_q + 32'd4;
   end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios followed by a randomized run
// checked against an instruction-stream reference model.
module tb_fetch_pc_unit;

   localparam logic [31:0] RPC = 32'h0040_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        jump = 1'b0;
   logic [31:0] jump_target = 32'd0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = 32'd0;
   logic        inst_valid;
   logic [31:0] inst, pc_out, pc_plus4;

   fetch_pc_unit_if mi ();

   fetch_pc_unit #(.RESET_PC(RPC)) dut (
      .clk(clk), .rst(rst), .stall(stall),
      .jump(jump), .jump_target(jump_target),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .imem(mi),
      .inst_valid(inst_valid), .inst(inst), .pc_out(pc_out), .pc_plus4(pc_plus4)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   // Memory behaviour knobs.
   int mem_wait    = 0;
   int wcnt        = 0;
   bit force_ready = 1'b0;

   // Reference model: next fetch address, held instruction, pending redirect.
   bit          m_idle  = 1'b1;
   bit          m_hold  = 1'b0;
   logic [31:0] m_addr  = RPC;
   bit          m_pend  = 1'b0;
   logic [31:0] m_ptgt  = 32'd0;
   logic [31:0] m_inst  = 32'd0;
   logic [31:0] m_pcout = 32'd0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == RPC) return 32'h2008_0005;
      return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
   endfunction

   // One clock: memory responds, edge, reference model advances.
   task automatic tick();
      logic        redir;
      logic [31:0] tgt;
      if (force_ready) begin
         mi.imem_ready = 1'b1;
         mi.imem_rdata = mem_word(mi.imem_addr);
      end else if (mi.imem_req && !rst) begin
         if (wcnt >= mem_wait) begin
            mi.imem_ready = 1'b1;
            mi.imem_rdata = mem_word(mi.imem_addr);
            wcnt = 0;
         end else begin
            mi.imem_ready = 1'b0;
            mi.imem_rdata = $urandom;
            wcnt++;
         end
      end else begin
         mi.imem_ready = 1'b0;
         mi.imem_rdata = $urandom;
         wcnt = 0;
      end
      if (rst) wcnt = 0;
      @(posedge clk);
      redir = jump || branch_taken;
      tgt   = jump ? {jump_target[31:2], 2'b00} : {branch_target[31:2], 2'b00};
      if (rst) begin
         m_idle = 1; m_hold = 0; m_addr = RPC; m_pend = 0; m_inst = 0; m_pcout = 0;
      end else if (m_idle) begin
         m_idle = 0;
      end else if (!m_hold) begin
         if (mi.imem_ready) begin
            if (redir)       begin m_addr = tgt;    m_pend = 0; end
            else if (m_pend) begin m_addr = m_ptgt; m_pend = 0; end
            else begin
               m_inst = mem_word(m_addr); m_pcout = m_addr;
               m_addr = m_addr + 32'd4;   m_hold = 1;
            end
         end else if (redir) begin
            m_pend = 1; m_ptgt = tgt;
         end
      end else begin
         if (redir) begin m_hold = 0; m_addr = tgt; end
         else if (!stall) m_hold = 0;
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      n_cmp++; if (mi.imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got %b want 0", mi.imem_req); end
      n_cmp++; if (mi.imem_addr !== RPC) begin n_fail++; $display("FAIL rst_addr got %h want %h", mi.imem_addr, RPC); end
      n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", inst_valid); end
      n_cmp++; if (inst !== 32'd0) begin n_fail++; $display("FAIL rst_inst got %h want 0", inst); end
      n_cmp++; if (pc_out !== 32'd0) begin n_fail++; $display("FAIL rst_pc_out got %h want 0", pc_out); end
      n_cmp++; if (pc_plus4 !== 32'd4) begin n_fail++; $display("FAIL rst_pc_plus4 got %h want 4", pc_plus4); end
   endtask

   task automatic test_first_fetch();
      rst = 1'b0;
      tick();
      n_cmp++; if (mi.imem_req !== 1'b1) begin n_fail++; $display("FAIL ff_req got %b want 1", mi.imem_req); end
      n_cmp++; if (mi.imem_addr !== RPC) begin n_fail++; $display("FAIL ff_addr got %h want %h", mi.imem_addr, RPC); end
      tick();
      n_cmp++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL ff_valid got %b want 1", inst_valid); end
      n_cmp++; if (inst !== 32'h2008_0005) begin n_fail++; $display("FAIL ff_inst got %h want 20080005", inst); end
      n_cmp++; if (pc_out !== RPC) begin n_fail++; $display("FAIL ff_pc_out got %h want %h", pc_out, RPC); end
      n_cmp++; if (pc_plus4 !== 32'h0040_0004) begin n_fail++; $display("FAIL ff_pc_plus4 got %h want 00400004", pc_plus4); end
      tick();
      n_cmp++; if (mi.imem_addr !== 32'h0040_0004 || mi.imem_req !== 1'b1) begin
         n_fail++; $display("FAIL ff_next got req=%b addr=%h want req=1 addr=00400004", mi.imem_req, mi.imem_addr); end
   endtask

   task automatic test_stall();
      logic [31:0] want;
      want = mem_word(32'h0040_0004);
      tick();
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         n_cmp++; if (inst_valid !== 1'b1 || inst !== want || pc_out !== 32'h0040_0004 || mi.imem_req !== 1'b0) begin
            n_fail++; $display("FAIL stall_hold%0d got v=%b inst=%h pc=%h req=%b want v=1 inst=%h pc=00400004 req=0",
                               k, inst_valid, inst, pc_out, mi.imem_req, want); end
      end
      stall = 1'b0;
      tick();
      n_cmp++; if (mi.imem_req !== 1'b1 || mi.imem_addr !== 32'h0040_0008) begin
         n_fail++; $display("FAIL stall_resume got req=%b addr=%h want req=1 addr=00400008", mi.imem_req, mi.imem_addr); end
   endtask

   task automatic test_redirect_mid_fetch();
      mem_wait = 3;
      tick();
      branch_taken = 1'b1; branch_target = 32'h0040_0103;
      tick();
      branch_taken = 1'b0; branch_target = 32'd0;
      n_cmp++; if (mi.imem_addr !== 32'h0040_0008 || inst_valid !== 1'b0) begin
         n_fail++; $display("FAIL midf_stable got addr=%h v=%b want addr=00400008 v=0", mi.imem_addr, inst_valid); end
      tick(); tick();
      n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL midf_drop got v=%b want 0", inst_valid); end
      n_cmp++; if (mi.imem_req !== 1'b1 || mi.imem_addr !== 32'h0040_0100) begin
         n_fail++; $display("FAIL midf_target got req=%b addr=%h want req=1 addr=00400100", mi.imem_req, mi.imem_addr); end
      mem_wait = 0;
      tick();
      n_cmp++; if (inst_valid !== 1'b1 || pc_out !== 32'h0040_0100 || inst !== mem_word(32'h0040_0100)) begin
         n_fail++; $display("FAIL midf_deliver got v=%b pc=%h inst=%h want v=1 pc=00400100 inst=%h",
                            inst_valid, pc_out, inst, mem_word(32'h0040_0100)); end
   endtask

   task automatic test_simul_redirect();
      jump = 1'b1; jump_target = 32'h0000_1000;
      branch_taken = 1'b1; branch_target = 32'h0000_2000;
      stall = 1'b1;
      tick();
      jump = 1'b0; branch_taken = 1'b0; stall = 1'b0;
      n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL simul_squash got v=%b want 0", inst_valid); end
      n_cmp++; if (mi.imem_req !== 1'b1 || mi.imem_addr !== 32'h0000_1000) begin
         n_fail++; $display("FAIL simul_prio got req=%b addr=%h want req=1 addr=00001000", mi.imem_req, mi.imem_addr); end
   endtask

   task automatic test_wrap();
      tick();
      jump = 1'b1; jump_target = 32'hFFFF_FFFC; stall = 1'b1;
      tick();
      jump = 1'b0; stall = 1'b0;
      n_cmp++; if (mi.imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr got %h want fffffffc", mi.imem_addr); end
      tick();
      n_cmp++; if (pc_out !== 32'hFFFF_FFFC || pc_plus4 !== 32'd0 || inst_valid !== 1'b1) begin
         n_fail++; $display("FAIL wrap_plus4 got pc=%h p4=%h v=%b want pc=fffffffc p4=0 v=1", pc_out, pc_plus4, inst_valid); end
      tick();
      n_cmp++; if (mi.imem_req !== 1'b1 || mi.imem_addr !== 32'd0) begin
         n_fail++; $display("FAIL wrap_next got req=%b addr=%h want req=1 addr=0", mi.imem_req, mi.imem_addr); end
   endtask

   task automatic test_reset_mid_fetch();
      mem_wait = 3;
      tick();
      rst = 1'b1;
      tick();
      n_cmp++; if (mi.imem_req !== 1'b0 || inst_valid !== 1'b0 || mi.imem_addr !== RPC) begin
         n_fail++; $display("FAIL rmid_reset got req=%b v=%b addr=%h want req=0 v=0 addr=%h", mi.imem_req, inst_valid, mi.imem_addr, RPC); end
      rst = 1'b0; force_ready = 1'b1;
      tick();
      force_ready = 1'b0; mem_wait = 0;
      n_cmp++; if (inst_valid !== 1'b0 || mi.imem_req !== 1'b1 || mi.imem_addr !== RPC) begin
         n_fail++; $display("FAIL rmid_ignore got v=%b req=%b addr=%h want v=0 req=1 addr=%h", inst_valid, mi.imem_req, mi.imem_addr, RPC); end
      tick();
      n_cmp++; if (inst_valid !== 1'b1 || pc_out !== RPC || inst !== 32'h2008_0005) begin
         n_fail++; $display("FAIL rmid_first got v=%b pc=%h inst=%h want v=1 pc=%h inst=20080005", inst_valid, pc_out, inst, RPC); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         rst           = ($urandom_range(0, 149) == 0);
         stall         = $urandom_range(0, 1);
         jump          = ($urandom_range(0, 9) == 0);
         branch_taken  = ($urandom_range(0, 7) == 0);
         jump_target   = $urandom;
         branch_target = $urandom;
         if ($urandom_range(0, 19) == 0) mem_wait = $urandom_range(0, 3);
         tick();
         n_cmp++; if (mi.imem_req !== (!m_idle && !m_hold)) begin
            n_fail++; $display("FAIL rnd_req cyc %0d got %b want %b", i, mi.imem_req, (!m_idle && !m_hold)); end
         n_cmp++; if (mi.imem_addr !== m_addr) begin
            n_fail++; $display("FAIL rnd_addr cyc %0d got %h want %h", i, mi.imem_addr, m_addr); end
         n_cmp++; if (inst_valid !== m_hold) begin
            n_fail++; $display("FAIL rnd_valid cyc %0d got %b want %b", i, inst_valid, m_hold); end
         n_cmp++; if (inst !== m_inst) begin
            n_fail++; $display("FAIL rnd_inst cyc %0d got %h want %h", i, inst, m_inst); end
         n_cmp++; if (pc_out !== m_pcout) begin
            n_fail++; $display("FAIL rnd_pc_out cyc %0d got %h want %h", i, pc_out, m_pcout); end
         n_cmp++; if (pc_plus4 !== m_pcout + 32'd4) begin
            n_fail++; $display("FAIL rnd_pc_plus4 cyc %0d got %h want %h", i, pc_plus4, m_pcout + 32'd4); end
      end
      rst = 1'b0; jump = 1'b0; branch_taken = 1'b0; stall = 1'b0;
   endtask

   initial begin
      mi.imem_ready = 1'b0;
      mi.imem_rdata = 32'd0;
      #2;
      test_reset();
      test_first_fetch();
      test_stall();
      test_redirect_mid_fetch();
      test_simul_redirect();
      test_wrap();
      test_reset_mid_fetch();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
